// File: rtl/cla_mp_seq.sv
// cla_mp_seq: multi-precision add/subtract sequencer around one 4-bit
// carry-lookahead slice. Operands are processed LSB nibble first, one nibble
// per clock, with the carry registered between nibbles.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request; accepted only in IDLE or DONE
//   a, b        WIDTH-bit operands, latched on accept
//   cin         carry-in for add (ignored when sub=1)
//   sub         1 = a-b, 0 = a+b+cin; latched on accept
//   busy        high while nibbles are being processed (RUN)
//   done        one-cycle pulse, result valid (DONE)
//   sum         registered result
//   cout        final carry (sub: 1 = no borrow)
//   ovf         signed overflow of the full-width result
//
// Handshake: start is a level request sampled at a rising edge only when the
// block is in IDLE or DONE; the accepting edge latches the operands. sum,
// cout and ovf are qualified by done and then hold until the next accept.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead carries.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_mp_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NNIB = WIDTH / 4;
  localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_mp_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             sgn_a_q;
  logic             sgn_b_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_s;
  logic             slice_co;

  assign last = (k_q == KW'(NNIB - 1));

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Nibble k of the latched operands feeds the single slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NNIB; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  cla4 u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  // Datapath. Subtraction is a + ~b + 1, so B is stored inverted and the
  // carry seeded with 1; sgn_b therefore reflects the inverted operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      sgn_a_q <= a[WIDTH-1];
      sgn_b_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      k_q     <= '0;
      sum_q   <= '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < NNIB; i++) begin
        if (k_q == KW'(i)) sum_q[4*i +: 4] <= slice_s;
      end
      carry_q <= slice_co;
      k_q     <= k_q + 1'b1;
      if (last) begin
        cout_q <= slice_co;
        ovf_q  <= (sgn_a_q == sgn_b_q) && (slice_s[3] != sgn_a_q);
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_mp_seq.sv
module tb_cla_mp_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic        sub4;
  logic        busy4;
  logic        done4;
  logic [3:0]  sum4;
  logic        cout4;
  logic        ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {sum, cout, ovf} for the 16-bit instance, in completion order.
  logic [17:0] exp_q[$];

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t vecs[9];

  cla_mp_seq #(.WIDTH(16)) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .a (a), .b (b),
    .cin (cin), .sub (sub), .busy (busy), .done (done), .sum (sum),
    .cout (cout), .ovf (ovf)
  );

  cla_mp_seq #(.WIDTH(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .start (start4), .a (a4), .b (b4),
    .cin (cin4), .sub (sub4), .busy (busy4), .done (done4), .sum (sum4),
    .cout (cout4), .ovf (ovf4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      check("busy4_done4_excl", {31'd0, busy4 & done4}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          check("sum",  {16'd0, sum}, {16'd0, e[17:2]});
          check("cout", {31'd0, cout}, {31'd0, e[1]});
          check("ovf",  {31'd0, ovf},  {31'd0, e[0]});
        end
      end
    end
  end

  // Driver: one operation, with inputs scrambled during RUN and an optional
  // stray start pulse driven at negedge index repulse_at (0 = none).
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                       input logic tcin, input logic tsub,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input int repulse_at);
    int cyc;
    int busy_cnt;
    int done_at;
    @(negedge clk);
    a = ta; b = tbv; cin = tcin; sub = tsub; start = 1'b1;
    exp_q.push_back({es, ec, eo});
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cnt = 0; done_at = 0;
    while (done_at == 0 && cyc < 20) begin
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = cyc;
      end else begin
        a     = 16'($urandom_range(0, 65535));
        b     = 16'($urandom_range(0, 65535));
        cin   = 1'($urandom_range(0, 1));
        sub   = 1'($urandom_range(0, 1));
        start = (cyc == repulse_at);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_latency", done_at, 5);
    check("busy_cycles", busy_cnt, 4);
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int first_done;
    int second_done;
    int gap_bad;
    int cyc;
    int stray;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h1235, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    vecs[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
            vecs[i].esum, vecs[i].ecout, vecs[i].eovf, 0);
    end

    // Stray start during RUN: ignored, same latency, no extra done.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 2);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back({16'h0007, 1'b0, 1'b0});
    @(negedge clk);
    a = 16'h00F0; b = 16'h0010;
    exp_q.push_back({16'h0100, 1'b0, 1'b0});
    first_done = 0; second_done = 0; gap_bad = 0; cyc = 0;
    while (second_done == 0 && cyc < 30) begin
      cyc++;
      if (first_done != 0 && !(busy || done)) gap_bad++;
      if (done) begin
        if (first_done == 0) first_done = cyc;
        else begin
          second_done = cyc;
          start = 1'b0;
        end
      end
      if (second_done == 0) @(negedge clk);
    end
    start = 1'b0;
    check("b2b_first_done", first_done, 5);
    check("b2b_gap", second_done - first_done, 5);
    check("b2b_no_idle", gap_bad, 0);
    @(negedge clk);
    check("b2b_done_drop", {31'd0, done}, 32'd0);

    // Reset during RUN: leave cout/ovf set first so the clear is visible.
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    @(negedge clk);
    a = 16'h0005; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sum",  {16'd0, sum}, 32'd0);
    check("arst_cout", {31'd0, cout}, 32'd0);
    check("arst_ovf",  {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    check("arst_no_resume", stray, 0);

    // WIDTH=4 instance: 0x9 + 0x8.
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("w4_busy", {31'd0, busy4}, 32'd1);
    check("w4_done_early", {31'd0, done4}, 32'd0);
    @(negedge clk);
    check("w4_done", {31'd0, done4}, 32'd1);
    check("w4_sum",  {28'd0, sum4}, 32'h1);
    check("w4_cout", {31'd0, cout4}, 32'd1);
    check("w4_ovf",  {31'd0, ovf4}, 32'd1);
    @(negedge clk);
    check("w4_done_drop", {31'd0, done4}, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_mp_seq.md
Name: cla_mp_seq

Overview:
Multi-precision add/subtract sequencer built around the team's existing 4-bit carry-lookahead adder slice (inputs a[3:0], b[3:0], cin; outputs s[3:0], cout). One slice instance is reused across cycles, LSB nibble first, to add or subtract WIDTH-bit operands, and the carry is registered between nibbles. The block sits between a control FSM or CPU register file and that single slice, and presents a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NNIB, WIDTH/4, derived: nibble count = RUN cycles per operation (not user-set)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A, latched when start is accepted
b  input  WIDTH  operand B, latched when start is accepted
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = compute a-b (two's complement), 0 = a+b+cin; latched on start
busy  output  1  high in RUN
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, registered
cout  output  1  final carry (for sub: 1 = no borrow, a>=b unsigned)
ovf  output  1  signed overflow of the full-width result

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state: IDLE. busy=0, done=0, sum=0, cout=0, ovf=0, and all internal operand, carry and index registers cleared. Reset mid-RUN aborts the operation; no done pulse is produced.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge: latch A=a, B = sub ? ~b : b, carry = sub ? 1 : cin, sgn_a=a[WIDTH-1], sgn_b=B[WIDTH-1], k=0, clear sum.
  - Go to RUN; busy=1 from the next cycle.
- RUN:
  - Each cycle the slice sees A[4k+3:4k], B[4k+3:4k] and the carry register.
  - At the edge: sum[4k+3:4k] <= slice s; carry <= slice cout; k <= k+1.
  - start is ignored in RUN. a, b, cin and sub may change freely without effect.
  - At the edge where k=NNIB-1: go to DONE, busy=0, done=1, cout <= slice cout, ovf <= (sgn_a==sgn_b) && (slice s[3] != sgn_a).
- DONE: lasts exactly one cycle; done=1.
  - Next edge with start=0: go to IDLE, done=0.
  - Next edge with start=1: accept it exactly as in IDLE (back-to-back operation), go to RUN, done=0.
- Latency: start sampled at edge E0; nibbles are processed at edges E1..ENNIB; done is high from ENNIB to ENNIB+1. For WIDTH=16, done appears after edge 4 counted from the accept edge.
- Output hold rules:
  - sum, cout and ovf hold their final values from DONE until the next accepted start.
  - sum upper nibbles read 0 during RUN (only done qualifies the result); cout and ovf keep their previous values until the final edge.
- Arithmetic:
  - Modulo 2^WIDTH; carry out of the top nibble goes only to cout.
  - sub with cin=1 and with cin=0 give identical results.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0; busy high for 4 cycles; done single pulse after edge 4.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x1235, sub=1 -> sum=0xFFFF, cout=0, ovf=0.
- a=0x8000, b=0x0001, sub=1, cin=0 -> sum=0x7FFF, cout=1, ovf=1; a repeat with cin=1 gives an identical result.
- Re-pulse start with different a/b at RUN cycle 2 -> ignored; original result delivered with unchanged latency; no extra done.
- start held high continuously, 0x0003+0x0004 then 0x00F0+0x0010 -> done pulses 5 cycles apart, sums 0x0007 then 0x0100, no IDLE cycle between.
- Assert rst_n=0 during RUN cycle 1 -> busy, done, sum, cout, ovf go 0 immediately (asynchronously); no done after release. WIDTH=4 build: 0x9+0x8 -> sum=0x1, cout=1, ovf=1, done after edge 1.
